// File: rtl/seven_segment_scan_ctrl_if.sv
// seven_segment_scan_ctrl_if: snapshot inputs and display outputs of the 7-segment scan controller.
//   master: digits, digit_en, dp_in out; an, seg, dp, frame_start in
//   slave : the scan controller side (directions reversed)
interface seven_segment_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_start;
    modport master (output digits, digit_en, dp_in, input an, seg, dp, frame_start);
    modport slave  (input digits, digit_en, dp_in, output an, seg, dp, frame_start);
endinterface

// File: rtl/seven_segment_scan_ctrl.sv
// seven_segment_scan_ctrl: time-multiplexed common-anode 7-segment scanner with per-frame input snapshot.
//   clk, rst_n (synchronous, active low)
//   bus.digits/digit_en/dp_in in; bus.an/seg/dp (active low, registered) and bus.frame_start out
//   Optional LEADING_ZERO_BLANK_EN: suppress leading zero digits above digit 0.
module seven_segment_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    seven_segment_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    typedef enum logic {BLANK, DRIVE} state_t;
    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d, snap_dp_q, snap_dp_d, an_q, an_d, keep;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d, take;
    logic [3:0]              cur;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0001100;
            default: decode = 7'b1111111;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Scan from the top digit down; a digit stays visible once any digit at or above it is non-zero.
    logic nz;
    always_comb begin
        nz   = 1'b0;
        keep = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz      = nz | (|snap_digits_q[4*i +: 4]);
            keep[i] = nz | (i == 0);
        end
    end
`else
    assign keep = '1;
`endif

    assign take = state_q == BLANK && idx_q == '0 && cnt_q == '0;
    assign cur  = snap_digits_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CW'(1);
        idx_d         = idx_q;
        snap_digits_d = take ? bus.digits : snap_digits_q;
        snap_en_d     = take ? bus.digit_en : snap_en_q;
        snap_dp_d     = take ? bus.dp_in : snap_dp_q;
        an_d          = an_q;
        seg_d         = seg_q;
        dp_d          = dp_q;
        if (state_q == BLANK && cnt_q == CW'(BLANK_CYCLES - 1)) begin
            state_d = DRIVE;
            cnt_d   = '0;
            an_d    = (snap_en_q[idx_q] & keep[idx_q]) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
            seg_d   = decode(cur);
            dp_d    = ~(snap_dp_q[idx_q] & keep[idx_q]);
        end else if (state_q == DRIVE && cnt_q == CW'(REFRESH_DIV - BLANK_CYCLES - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
            an_d    = '1;
            seg_d   = '1;
            dp_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= BLANK;
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_digits_q <= '0;
            snap_en_q     <= '0;
            snap_dp_q     <= '0;
            an_q          <= '1;
            seg_q         <= '1;
            dp_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_digits_q <= snap_digits_d;
            snap_en_q     <= snap_en_d;
            snap_dp_q     <= snap_dp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    // frame_start is combinational so it is high in the snapshot cycle itself, held low during reset.
    assign bus.frame_start = rst_n & take;
    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// tb_seven_segment_scan_ctrl: directed checks of scan timing, decode, snapshot, enables, reset and zero blanking.
module tb_seven_segment_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [3:0] an_h [64];
    logic [6:0] seg_h [64];
    logic       dp_h [64];
    logic       fs_h [64];

    always #5 clk = ~clk;

    seven_segment_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seven_segment_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic set_in(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p);
        bus.digits   = d;
        bus.digit_en = e;
        bus.dp_in    = p;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Releases reset at a falling edge; entry c of the history is cycle c after release.
    task automatic capture(input int n, input int chg_at, input logic [15:0] chg_val);
        rst_n = 1'b1;
        for (int c = 0; c < n; c++) begin
            if (c == chg_at) bus.digits = chg_val;
            #1;
            an_h[c]  = bus.an;
            seg_h[c] = bus.seg;
            dp_h[c]  = bus.dp;
            fs_h[c]  = bus.frame_start;
            @(negedge clk);
        end
    endtask

    task automatic check_startup(input string tag);
        checks++;
        if (fs_h[0] !== 1'b1) begin errors++; $display("FAIL %s fs0: got %b want 1", tag, fs_h[0]); end
        for (int c = 1; c < 32; c++) begin
            checks++;
            if (fs_h[c] !== 1'b0) begin errors++; $display("FAIL %s fs cycle %0d: got %b want 0", tag, c, fs_h[c]); end
        end
        checks++;
        if (fs_h[32] !== 1'b1) begin errors++; $display("FAIL %s fs32: got %b want 1", tag, fs_h[32]); end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (an_h[c] !== 4'b1111) begin errors++; $display("FAIL %s an cycle %0d: got %b want 1111", tag, c, an_h[c]); end
        end
        for (int c = 2; c < 8; c++) begin
            checks++;
            if (an_h[c] !== 4'b1110) begin errors++; $display("FAIL %s an cycle %0d: got %b want 1110", tag, c, an_h[c]); end
        end
        for (int c = 8; c < 10; c++) begin
            checks++;
            if (an_h[c] !== 4'b1111) begin errors++; $display("FAIL %s an cycle %0d: got %b want 1111", tag, c, an_h[c]); end
        end
        checks++;
        if (an_h[10] !== 4'b1101) begin errors++; $display("FAIL %s an cycle 10: got %b want 1101", tag, an_h[10]); end
    endtask

    task automatic test_reset();
        set_in(16'h1234, 4'b1111, 4'b0100);
        hold_reset();
        #1;
        checks++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset outputs: got an=%b seg=%b dp=%b fs=%b want 1111 1111111 1 0", bus.an, bus.seg, bus.dp, bus.frame_start);
        end
        @(negedge clk);
        capture(40, -1, 16'h0);
        check_startup("startup");
    endtask

    task automatic test_decode();
        logic [3:0] an_e [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] seg_e [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        logic       dp_e [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        set_in(16'h1234, 4'b1111, 4'b0100);
        hold_reset();
        capture(32, -1, 16'h0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({an_h[8*k+4], seg_h[8*k+4], dp_h[8*k+4]} !== {an_e[k], seg_e[k], dp_e[k]}) begin
                errors++;
                $display("FAIL decode digit %0d: got an=%b seg=%b dp=%b want %b %b %b", k, an_h[8*k+4], seg_h[8*k+4], dp_h[8*k+4], an_e[k], seg_e[k], dp_e[k]);
            end
        end
        checks++;
        if ({seg_h[8], dp_h[8]} !== {7'b1111111, 1'b1}) begin
            errors++; $display("FAIL decode gap: got seg=%b dp=%b want 1111111 1", seg_h[8], dp_h[8]);
        end
        for (int c = 0; c < 32; c++) begin
            checks++;
            if (dp_h[c] !== (an_h[c] != 4'b1011)) begin
                errors++; $display("FAIL dp cycle %0d: got dp=%b with an=%b", c, dp_h[c], an_h[c]);
            end
        end
    endtask

    task automatic test_snapshot();
        int         cyc [8]   = '{12, 20, 28, 36, 44, 52, 60, 4};
        logic [6:0] seg_e [8] = '{7'b0000110, 7'b0010010, 7'b1001111, 7'b0000000,
                                  7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100};
        set_in(16'h1234, 4'b1111, 4'b0000);
        hold_reset();
        capture(64, 12, 16'h5678);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (seg_h[cyc[k]] !== seg_e[k]) begin
                errors++; $display("FAIL snapshot cycle %0d: got seg=%b want %b", cyc[k], seg_h[cyc[k]], seg_e[k]);
            end
        end
        checks++;
        if (fs_h[32] !== 1'b1) begin errors++; $display("FAIL snapshot fs32: got %b want 1", fs_h[32]); end
    endtask

    task automatic test_enable();
        set_in(16'h00B0, 4'b0101, 4'b0000);
        hold_reset();
        capture(32, -1, 16'h0);
        for (int c = 0; c < 32; c++) begin
            logic [3:0] want;
            want = 4'b1111;
            if (c % 8 >= 2 && c / 8 == 0) want = 4'b1110;
            if (c % 8 >= 2 && c / 8 == 2) want = 4'b1011;
            checks++;
            if (an_h[c] !== want) begin errors++; $display("FAIL enable an cycle %0d: got %b want %b", c, an_h[c], want); end
        end
        checks++;
        if (seg_h[4] !== 7'b0000001) begin errors++; $display("FAIL enable digit0 seg: got %b want 0000001", seg_h[4]); end
        set_in(16'h00B0, 4'b1111, 4'b0000);
        hold_reset();
        capture(16, -1, 16'h0);
        checks++;
        if ({an_h[12], seg_h[12]} !== {4'b1101, 7'b1111111}) begin
            errors++; $display("FAIL hex blank: got an=%b seg=%b want 1101 1111111", an_h[12], seg_h[12]);
        end
    endtask

    task automatic test_mid_reset();
        set_in(16'h1234, 4'b1111, 4'b0000);
        hold_reset();
        capture(13, -1, 16'h0);
        #1;
        checks++;
        if (bus.an !== 4'b1101) begin errors++; $display("FAIL midreset before: got an=%b want 1101", bus.an); end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midreset blank: got an=%b seg=%b dp=%b fs=%b want 1111 1111111 1 0", bus.an, bus.seg, bus.dp, bus.frame_start);
        end
        repeat (2) @(negedge clk);
        capture(34, -1, 16'h0);
        check_startup("midreset");
    endtask

    task automatic test_lzb();
        logic [3:0] an2, an3;
        logic       dp2, dp3;
`ifdef LEADING_ZERO_BLANK_EN
        an2 = 4'b1111; an3 = 4'b1111; dp2 = 1'b1; dp3 = 1'b1;
`else
        an2 = 4'b1011; an3 = 4'b0111; dp2 = 1'b0; dp3 = 1'b0;
`endif
        set_in(16'h0070, 4'b1111, 4'b1100);
        hold_reset();
        capture(32, -1, 16'h0);
        checks++;
        if ({an_h[4], seg_h[4]} !== {4'b1110, 7'b0000001}) begin
            errors++; $display("FAIL lzb digit0: got an=%b seg=%b want 1110 0000001", an_h[4], seg_h[4]);
        end
        checks++;
        if ({an_h[12], seg_h[12]} !== {4'b1101, 7'b0001111}) begin
            errors++; $display("FAIL lzb digit1: got an=%b seg=%b want 1101 0001111", an_h[12], seg_h[12]);
        end
        checks++;
        if ({an_h[20], dp_h[20]} !== {an2, dp2}) begin
            errors++; $display("FAIL lzb digit2: got an=%b dp=%b want %b %b", an_h[20], dp_h[20], an2, dp2);
        end
        checks++;
        if ({an_h[28], dp_h[28]} !== {an3, dp3}) begin
            errors++; $display("FAIL lzb digit3: got an=%b dp=%b want %b %b", an_h[28], dp_h[28], an3, dp3);
        end
    endtask

    initial begin
        set_in(16'h0, 4'h0, 4'h0);
        test_reset();
        test_decode();
        test_snapshot();
        test_enable();
        test_mid_reset();
        test_lzb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
